// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and frame geometry.
// The receiver imports this package too.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    // One-hot so an illegal encoding is easy to spot and recover from.
    typedef enum logic [3:0] {
        TxIdle     = 4'b0001,
        TxStartBit = 4'b0010,
        TxDataBit  = 4'b0100,
        TxStopBit  = 4'b1000
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buf_if.sv
// Byte-stream valid/ready handshake feeding the buffered UART transmitter.
interface uart_tx_buf_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] din;
    logic                   din_valid;
    logic                   din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is dropped.
module uart_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             push_en, pop_en;

    // Full is judged before the pop, so a push into a full FIFO is lost even if it pops.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AddrW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_ptr_q[AddrW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: FIFO-fed, back-to-back frames with no idle gap.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned NUM_CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_buf_if.slave  in_bus,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    localparam int unsigned CntW = $clog2(NUM_CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(NUM_CLKS_PER_BIT - 1);

    tx_state_t              state_q, state_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;

    assign in_bus.din_ready = !fifo_full && !rst;
    assign fifo_push        = in_bus.din_valid && in_bus.din_ready;

    uart_sync_fifo #(
        .Width (UART_DATA_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_bus.din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            TxIdle: begin
                count_d   = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = TxStartBit;
                end
            end
            TxStartBit: begin
                if (count_q == CntMax) begin
                    count_d   = '0;
                    bit_idx_d = '0;
                    state_d   = TxDataBit;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            TxDataBit: begin
                if (count_q == CntMax) begin
                    count_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TxStopBit;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            TxStopBit: begin
                if (count_q == CntMax) begin
                    count_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = TxStartBit;
                    end else begin
                        state_d = TxIdle;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d   = TxIdle;
                count_d   = '0;
                bit_idx_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        case (state_d)
            TxStartBit: tx_d = 1'b0;
            TxDataBit:  tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase
        done_d = (state_d == TxStopBit) && (count_d == CntMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TxIdle;
            count_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx   = tx_q;
    assign done = done_q;
    assign busy = (state_q != TxIdle) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: N=16/depth 4 instance plus an N=5/depth 2 instance.
module tb_uart_tx_buf;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_buf_if bus16();
    uart_tx_buf_if bus5();
    logic tx16, busy16, done16;
    logic tx5, busy5, done5;

    uart_tx_buf #(.NUM_CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut16 (
        .clk(clk), .rst(rst), .in_bus(bus16), .tx(tx16), .busy(busy16), .done(done16)
    );
    uart_tx_buf #(.NUM_CLKS_PER_BIT(5), .FIFO_DEPTH(2)) dut5 (
        .clk(clk), .rst(rst), .in_bus(bus5), .tx(tx5), .busy(busy5), .done(done5)
    );

    logic sel = 1'b0;
    logic tx_mon, done_mon, busy_mon;
    assign tx_mon   = sel ? tx5 : tx16;
    assign done_mon = sel ? done5 : done16;
    assign busy_mon = sel ? busy5 : busy16;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts idle negedges until tx falls; a frame starting on the next cycle gives 0.
    task automatic wait_fall(input int limit, output int gap);
        gap = 0;
        @(negedge clk);
        while (tx_mon !== 1'b0 && gap < limit) begin
            gap++;
            @(negedge clk);
        end
        if (tx_mon !== 1'b0) check_eq("tx_fall_timeout", gap, -1);
    endtask

    // Entered on the first start-bit cycle; returns on the last stop-bit cycle.
    task automatic run_frame(input int n, input logic [7:0] b, input string tag);
        int errs = 0, done_at = -1, done_cnt = 0, bitno;
        logic [7:0] rec = '0;
        logic e;
        for (int c = 0; c < UART_FRAME_BITS * n; c++) begin
            if (c > 0) @(negedge clk);
            bitno = c / n;
            if (bitno == 0)      e = 1'b0;
            else if (bitno == 9) e = 1'b1;
            else                 e = b[bitno-1];
            if (tx_mon !== e) errs++;
            if (bitno >= 1 && bitno <= 8 && (c % n) == n / 2) rec[bitno-1] = tx_mon;
            if (done_mon === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
        end
        check_eq({tag, "_rx_byte"}, int'(rec), int'(b));
        check_eq({tag, "_wave_errs"}, errs, 0);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_done_pos"}, done_at, UART_FRAME_BITS * n - 1);
    endtask

    logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C, 8'h11};

    initial begin
        int gap, w, lows, dones, busies;
        bus16.din = '0; bus16.din_valid = 1'b0;
        bus5.din  = '0; bus5.din_valid  = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx16, 1);
        check_eq("rst_busy", busy16, 0);
        check_eq("rst_done", done16, 0);
        check_eq("rst_ready_held", bus16.din_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_ready", bus16.din_ready, 1);
        check_eq("rst_ready5", bus5.din_ready, 1);
        @(negedge clk);

        // Single byte 0xA5
        fork
            begin
                bus16.din = 8'hA5; bus16.din_valid = 1'b1;
                @(negedge clk);
                bus16.din_valid = 1'b0;
            end
            begin
                wait_fall(20, gap);
                check_eq("a5_latency", gap, 1);
                run_frame(16, 8'hA5, "a5");
                @(negedge clk);
                check_eq("a5_busy_after", busy16, 0);
                check_eq("a5_tx_idle", tx16, 1);
            end
        join
        repeat (3) @(negedge clk);

        // Burst of five into depth 4, then 0x11 held against back-pressure
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    bus16.din = burst[i]; bus16.din_valid = 1'b1;
                    if (i == 4) check_eq("burst_ready_5th", bus16.din_ready, 1);
                    @(negedge clk);
                end
                check_eq("burst_ready_full", bus16.din_ready, 0);
                bus16.din = 8'h11;
                w = 0;
                while (!bus16.din_ready && w < 1000) begin
                    @(negedge clk);
                    w++;
                end
                // Slot frees only at the first pop, one cycle after frame 0's stop bit ends.
                check_eq("bp_wait", w, 157);
                @(negedge clk);
                bus16.din_valid = 1'b0;
            end
            begin
                wait_fall(20, gap);
                check_eq("burst_latency", gap, 1);
                run_frame(16, burst[0], "burst0");
                for (int i = 1; i < 6; i++) begin
                    wait_fall(400, gap);
                    check_eq($sformatf("burst%0d_gap", i), gap, 0);
                    run_frame(16, burst[i], $sformatf("burst%0d", i));
                end
                @(negedge clk);
                check_eq("burst_busy_after", busy16, 0);
            end
        join
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0xC3 with two bytes queued
        fork
            begin
                bus16.din = 8'hC3; bus16.din_valid = 1'b1; @(negedge clk);
                bus16.din = 8'h01; @(negedge clk);
                bus16.din = 8'h02; @(negedge clk);
                bus16.din_valid = 1'b0;
            end
            begin
                wait_fall(20, gap);
                check_eq("mid_latency", gap, 1);
                repeat (4 * 16 + 5) @(negedge clk);
                check_eq("mid_in_bit3", tx16, 0);
                rst = 1'b1;
                @(negedge clk);
                check_eq("mid_tx", tx16, 1);
                check_eq("mid_busy", busy16, 0);
                check_eq("mid_done", done16, 0);
                rst = 1'b0;
                #1;
                check_eq("mid_ready", bus16.din_ready, 1);
                lows = 0; dones = 0; busies = 0;
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if (tx16 !== 1'b1) lows++;
                    if (done16 !== 1'b0) dones++;
                    if (busy16 !== 1'b0) busies++;
                end
                check_eq("mid_no_frames", lows, 0);
                check_eq("mid_no_done", dones, 0);
                check_eq("mid_no_busy", busies, 0);
            end
        join

        // N=5, depth 2, byte 0x80: 50-clock frame, bit 7 high on clocks 40-44
        sel = 1'b1;
        fork
            begin
                bus5.din = 8'h80; bus5.din_valid = 1'b1;
                @(negedge clk);
                bus5.din_valid = 1'b0;
            end
            begin
                wait_fall(20, gap);
                check_eq("n5_latency", gap, 1);
                run_frame(5, 8'h80, "n5");
                @(negedge clk);
                check_eq("n5_busy_after", busy_mon, 0);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
